// File: rtl/pitch_event_pkg.sv
// Shared types and default periods for the FFT pitch event filter.
package pitch_event_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        QUAL_HI = 3'd1,
        QUAL_LO = 3'd2,
        HELD_HI = 3'd3,
        HELD_LO = 3'd4,
        LOCKOUT = 3'd5
    } state_e;

    // Periods in clk_100mhz cycles: 20 ms dwell, 100 ms lockout, 300 ms repeat.
    localparam int unsigned DEF_DWELL_CYCLES   = 2_000_000;
    localparam int unsigned DEF_LOCKOUT_CYCLES = 10_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES  = 30_000_000;
    localparam int unsigned DEF_CNT_W          = 25;

endpackage

// File: rtl/pitch_event_filter_if.sv
// Pitch flag inputs and qualified navigation event outputs of pitch_event_filter.
interface pitch_event_filter_if;

    logic       enable;
    logic       hi_in;
    logic       lo_in;
    logic       hi_pulse;
    logic       lo_pulse;
    logic [7:0] event_count;
    logic [2:0] state_out;

    modport master (
        output enable, hi_in, lo_in,
        input  hi_pulse, lo_pulse, event_count, state_out
    );

    modport slave (
        input  enable, hi_in, lo_in,
        output hi_pulse, lo_pulse, event_count, state_out
    );

endinterface

// File: rtl/pitch_event_filter_event_timer.sv
// Up counter with clear and increment enable, flagging when it equals a supplied terminal value.
module event_timer #(
    parameter int unsigned CNT_W = 25
) (
    input  logic             clk_100mhz,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // NOTE: next-state logic assigns a default first so no path leaves count_d unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == term);

endmodule

// File: rtl/pitch_event_filter.sv
// Qualifies synchronized FFT hi/lo pitch flags into single-cycle navigation events.
// Define AUTOREPEAT_EN to emit repeat events while a tone is held.
module pitch_event_filter
    import pitch_event_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES   = DEF_DWELL_CYCLES,
    parameter int unsigned LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int unsigned REPEAT_CYCLES  = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic               clk_100mhz,
    input  logic               reset,
    pitch_event_filter_if.slave bus
);

    localparam logic [CNT_W-1:0] DWELL_TERM   = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCKOUT_TERM = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_TERM  = CNT_W'(REPEAT_CYCLES - 1);

    state_e           state_d, state_q;
    logic             hi_pulse_d, hi_pulse_q;
    logic             lo_pulse_d, lo_pulse_q;
    logic [7:0]       event_count_d, event_count_q;
    logic             tmr_clear, tmr_inc, tmr_at_term;
    logic [CNT_W-1:0] tmr_term;
    logic             is_hi, own, other;

    event_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .clear      (tmr_clear),
        .inc        (tmr_inc),
        .term       (tmr_term),
        .at_term    (tmr_at_term)
    );

    // Direction the qualifying/held state tracks, and its own versus opposing flag.
    assign is_hi = (state_q == QUAL_HI) || (state_q == HELD_HI);
    assign own   = is_hi ? bus.hi_in : bus.lo_in;
    assign other = is_hi ? bus.lo_in : bus.hi_in;

    always_comb begin
        state_d    = state_q;
        hi_pulse_d = 1'b0;
        lo_pulse_d = 1'b0;
        tmr_clear  = 1'b0;
        tmr_inc    = 1'b0;
        tmr_term   = DWELL_TERM;

        unique case (state_q)
            IDLE: begin
                tmr_clear = 1'b1;
                if (bus.hi_in && !bus.lo_in) begin
                    state_d = QUAL_HI;
                end else if (bus.lo_in && !bus.hi_in) begin
                    state_d = QUAL_LO;
                end
            end
            QUAL_HI, QUAL_LO: begin
                if (!own || other) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else if (tmr_at_term) begin
                    hi_pulse_d = is_hi;
                    lo_pulse_d = !is_hi;
                    state_d    = is_hi ? HELD_HI : HELD_LO;
                    tmr_clear  = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            HELD_HI, HELD_LO: begin
                tmr_term = REPEAT_TERM;
                if (!own) begin
                    state_d   = LOCKOUT;
                    tmr_clear = 1'b1;
                end else begin
`ifdef AUTOREPEAT_EN
                    if (tmr_at_term) begin
                        hi_pulse_d = is_hi;
                        lo_pulse_d = !is_hi;
                        tmr_clear  = 1'b1;
                    end else begin
                        tmr_inc = 1'b1;
                    end
`else
                    tmr_clear = 1'b1;
`endif
                end
            end
            LOCKOUT: begin
                tmr_term = LOCKOUT_TERM;
                if (tmr_at_term) begin
                    state_d   = IDLE;
                    tmr_clear = 1'b1;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                tmr_clear = 1'b1;
            end
        endcase

        // Disabling the filter wins over every transition above.
        if (!bus.enable) begin
            state_d    = IDLE;
            hi_pulse_d = 1'b0;
            lo_pulse_d = 1'b0;
            tmr_clear  = 1'b1;
            tmr_inc    = 1'b0;
        end

        event_count_d = event_count_q;
        if (hi_pulse_d || lo_pulse_d) begin
            event_count_d = event_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state_q       <= IDLE;
            hi_pulse_q    <= 1'b0;
            lo_pulse_q    <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            hi_pulse_q    <= hi_pulse_d;
            lo_pulse_q    <= lo_pulse_d;
            event_count_q <= event_count_d;
        end
    end

    assign bus.hi_pulse    = hi_pulse_q;
    assign bus.lo_pulse    = lo_pulse_q;
    assign bus.event_count = event_count_q;
    assign bus.state_out   = state_q;

endmodule
